// File: rtl/uart_pkg.sv
// Shared UART types and helpers: receiver state encoding and baud divisor calculation.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } uart_rx_state_t;

    // Clocks per oversample tick, truncated toward zero.
    function automatic int unsigned baud_div(input int unsigned clk_freq,
                                             input int unsigned baud,
                                             input int unsigned os);
        return clk_freq / (baud * os);
    endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Free-running modulo-DIV counter producing a registered one-clk tick every DIV clocks.
module baud_tick_gen #(
    parameter int unsigned DIV = 54
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int unsigned CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick_q, tick_d;

    // Wrap the counter at DIV-1 and flag the wrap as a tick.
    always_comb begin
        tick_d = (cnt_q == LAST);
        cnt_d  = tick_d ? '0 : cnt_q + CW'(1);
    end

    // Counter and tick registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1 LSB first with OVERSAMPLE-times oversampling.
// Define UART_RX_PARITY_EN for 8E1 framing with an extra parity_err strobe.
// rx_data holds the last good byte between rx_ready strobes.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 100_000_000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_ready,
    output logic       frame_err
`ifdef UART_RX_PARITY_EN
    ,
    output logic       parity_err
`endif
);

    localparam int unsigned DIV = baud_div(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int unsigned SW  = $clog2(OVERSAMPLE);
    localparam logic [SW-1:0] S_MID = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] S_END = SW'(OVERSAMPLE - 1);

    logic           sync1_q, sync2_q;
    logic           rxs;
    logic           tick;

    uart_rx_state_t state_q, state_d;
    logic [SW-1:0]  scnt_q, scnt_d;
    logic [2:0]     bcnt_q, bcnt_d;
    logic [7:0]     shift_q, shift_d;
    logic [7:0]     rx_data_q, rx_data_d;
    logic           rx_ready_q, rx_ready_d;
    logic           frame_err_q, frame_err_d;
`ifdef UART_RX_PARITY_EN
    logic           par_q, par_d;
    logic           parity_err_q, parity_err_d;
`endif

    // Two-flop synchronizer for the asynchronous line; resets to idle-high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= rx;
            sync2_q <= sync1_q;
        end
    end

    assign rxs = sync2_q;

    baud_tick_gen #(
        .DIV(DIV)
    ) u_tick (
        .clk  (clk),
        .reset(reset),
        .tick (tick)
    );

    // Next-state logic: frame sequencing, bit sampling and strobe generation.
    always_comb begin
        state_d     = state_q;
        scnt_d      = scnt_q;
        bcnt_d      = bcnt_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        rx_ready_d  = 1'b0;
        frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d        = par_q;
        parity_err_d = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (!rxs) begin
                    scnt_d  = '0;
                    state_d = START;
                end
            end
            START: begin
                if (tick) begin
                    if (scnt_q == S_MID) begin
                        if (!rxs) begin
                            scnt_d  = '0;
                            bcnt_d  = '0;
                            state_d = DATA;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        scnt_d = scnt_q + SW'(1);
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (scnt_q == S_END) begin
                        shift_d = {rxs, shift_q[7:1]};
                        scnt_d  = '0;
                        if (bcnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end else begin
                            bcnt_d = bcnt_q + 3'd1;
                        end
                    end else begin
                        scnt_d = scnt_q + SW'(1);
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    if (scnt_q == S_END) begin
                        par_d   = rxs;
                        scnt_d  = '0;
                        state_d = STOP;
                    end else begin
                        scnt_d = scnt_q + SW'(1);
                    end
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    if (scnt_q == S_END) begin
                        if (rxs) begin
`ifdef UART_RX_PARITY_EN
                            if (^{shift_q, par_q}) begin
                                parity_err_d = 1'b1;
                            end else begin
                                rx_data_d  = shift_q;
                                rx_ready_d = 1'b1;
                            end
`else
                            rx_data_d  = shift_q;
                            rx_ready_d = 1'b1;
`endif
                            state_d = IDLE;
                        end else begin
                            frame_err_d = 1'b1;
                            state_d     = BREAK;
                        end
                    end else begin
                        scnt_d = scnt_q + SW'(1);
                    end
                end
            end
            BREAK: begin
                // A held-low line stays here so it reports only one frame error.
                if (rxs) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM, datapath and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            scnt_q      <= '0;
            bcnt_q      <= '0;
            shift_q     <= '0;
            rx_data_q   <= 8'h00;
            rx_ready_q  <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q        <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            scnt_q      <= scnt_d;
            bcnt_q      <= bcnt_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rx_ready_q  <= rx_ready_d;
            frame_err_q <= frame_err_d;
`ifdef UART_RX_PARITY_EN
            par_q        <= par_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_ready  = rx_ready_q;
    assign frame_err = frame_err_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: frame-level model with expected-strobe queue.
`timescale 1ns/1ps
module tb_uart_rx;

    // 7.5 MHz / (115200*16) = 4.07 -> DIV 4, bit period 64 clks.
    localparam int unsigned CLK_FREQ = 7_500_000;
    localparam int unsigned BAUD     = 115200;
    localparam int unsigned OS       = 16;
    localparam int DIV = 4;
    localparam int BIT = DIV * OS;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
    localparam int NPRE   = 10;
`else
    localparam bit PAR_EN = 1'b0;
    localparam int NPRE   = 9;
`endif
    // Strobe lands mid stop bit: NPRE + 0.5 bit times after the start edge.
    localparam int LAT = (2 * NPRE + 1) * BIT / 2;
    localparam int TOL = 2 * DIV + 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       frame_err;
    logic       parity_err;
`ifndef UART_RX_PARITY_EN
    assign parity_err = 1'b0;
`endif

    uart_rx #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD      (BAUD),
        .OVERSAMPLE(OS)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rx       (rx),
        .rx_data  (rx_data),
        .rx_ready (rx_ready),
        .frame_err(frame_err)
`ifdef UART_RX_PARITY_EN
        ,
        .parity_err(parity_err)
`endif
    );

    always #5 clk = ~clk;

    // kind: 0 = rx_ready, 1 = frame_err, 2 = parity_err
    typedef struct {
        int         kind;
        logic [7:0] data;
        longint     lo;
        longint     hi;
    } ev_t;

    ev_t        exp_q[$];
    longint     cyc = 0;
    int         checks = 0;
    int         failures = 0;
    int         n_ready = 0;
    int         n_ferr = 0;
    int         n_perr = 0;
    logic [7:0] model_data = 8'h00;
    int         obs_kind;
    logic       multi;
    ev_t        cur;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            if (failures <= 20)
                $display("FAIL %s: got %0h expected %0h at cycle %0d", name, got, want, cyc);
        end
    endtask

    // Compare DUT strobes and held data against the expected-event queue every cycle.
    always @(negedge clk) begin
        if (reset) begin
            model_data = 8'h00;
        end else begin
            multi = (rx_ready && frame_err) || (rx_ready && parity_err) || (frame_err && parity_err);
            check("single_strobe", 32'(multi), 32'd0);
            if (rx_ready || frame_err || parity_err) begin
                obs_kind = rx_ready ? 0 : (frame_err ? 1 : 2);
                if (rx_ready)   n_ready++;
                if (frame_err)  n_ferr++;
                if (parity_err) n_perr++;
                if (exp_q.size() == 0) begin
                    check("unexpected_strobe", 32'(obs_kind), 32'd3);
                end else begin
                    cur = exp_q.pop_front();
                    check("strobe_kind", 32'(obs_kind), 32'(cur.kind));
                    check("strobe_time", 32'(cyc >= cur.lo && cyc <= cur.hi), 32'd1);
                    if (cur.kind == 0) model_data = cur.data;
                    check("rx_data_update", 32'(rx_data), 32'(model_data));
                end
            end else begin
                if (exp_q.size() != 0 && cyc > exp_q[0].hi) begin
                    cur = exp_q.pop_front();
                    check("strobe_missing", 32'({parity_err, frame_err, rx_ready}), 32'd1 << cur.kind);
                end
                check("rx_data_hold", 32'(rx_data), 32'(model_data));
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic v);
        rx = v;
        idle(BIT);
    endtask

    // Drive one frame and queue the outcome the framing rules demand.
    task automatic send_frame(input logic [7:0] b, input logic par, input logic stop);
        ev_t e;
        e.data = b;
        e.lo   = cyc + LAT - TOL;
        e.hi   = cyc + LAT + TOL;
        if (!stop)                      e.kind = 1;
        else if (PAR_EN && (^{b, par})) e.kind = 2;
        else                            e.kind = 0;
        exp_q.push_back(e);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        if (PAR_EN) drive_bit(par);
        drive_bit(stop);
    endtask

    task automatic send_good(input logic [7:0] b);
        send_frame(b, ^b, 1'b1);
    endtask

    initial begin
        #(100_000 * 10);
        $display("FAIL watchdog: got timeout expected finish at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        rx    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_rx_data", 32'(rx_data), 32'h00);
        check("reset_rx_ready", 32'(rx_ready), 32'd0);
        check("reset_frame_err", 32'(frame_err), 32'd0);
        reset = 1'b0;
        idle(20);

        // Single byte, then a long idle stretch with data held.
        send_good(8'hA5);
        idle(10000);
        check("a5_held", 32'(rx_data), 32'hA5);
        check("a5_count", 32'(n_ready), 32'd1);

        // Back-to-back frames with no idle gap.
        send_good(8'h12);
        send_good(8'h34);
        send_good(8'h56);
        idle(2 * BIT);
        check("b2b_last", 32'(rx_data), 32'h56);
        check("b2b_count", 32'(n_ready), 32'd4);
        check("b2b_no_ferr", 32'(n_ferr), 32'd0);

        // Short low glitch shorter than half a bit: rejected.
        rx = 1'b0;
        idle(BIT / 4);
        rx = 1'b1;
        idle(3 * BIT);
        check("glitch_no_ready", 32'(n_ready), 32'd4);
        check("glitch_no_ferr", 32'(n_ferr), 32'd0);
        send_good(8'h7E);
        idle(2 * BIT);
        check("after_glitch", 32'(rx_data), 32'h7E);

        // Bad stop bit with the line held low: one frame error, data kept.
        send_good(8'hA5);
        send_frame(8'h3C, ^8'h3C, 1'b0);
        rx = 1'b0;
        idle(3 * BIT);
        rx = 1'b1;
        idle(BIT);
        check("ferr_count", 32'(n_ferr), 32'd1);
        check("ferr_data_kept", 32'(rx_data), 32'hA5);
        check("ferr_ready_count", 32'(n_ready), 32'd6);
        send_good(8'h81);
        idle(2 * BIT);
        check("after_ferr", 32'(rx_data), 32'h81);

        // Reset in the middle of data bit 4 of 0xFF.
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1);
        rx = 1'b1;
        idle(BIT / 2);
        reset = 1'b1;
        #1;
        check("async_rst_rx_data", 32'(rx_data), 32'h00);
        check("async_rst_ready", 32'(rx_ready), 32'd0);
        check("async_rst_ferr", 32'(frame_err), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        idle(BIT / 2 + 5 * BIT);
        check("rst_no_strobe", 32'(n_ready), 32'd7);
        check("rst_data_zero", 32'(rx_data), 32'h00);
        send_good(8'h5A);
        idle(2 * BIT);
        check("after_reset", 32'(rx_data), 32'h5A);
        check("after_reset_count", 32'(n_ready), 32'd8);

`ifdef UART_RX_PARITY_EN
        // Even parity: 0x07 has three ones, so the parity bit must be 1.
        send_frame(8'h07, 1'b1, 1'b1);
        idle(2 * BIT);
        check("par_good_data", 32'(rx_data), 32'h07);
        check("par_good_count", 32'(n_ready), 32'd9);
        send_good(8'h11);
        send_frame(8'h07, 1'b0, 1'b1);
        idle(2 * BIT);
        check("par_bad_perr", 32'(n_perr), 32'd1);
        check("par_bad_no_ready", 32'(n_ready), 32'd10);
        check("par_bad_data_kept", 32'(rx_data), 32'h11);
`endif

        idle(2 * BIT);
        check("no_pending_events", 32'(exp_q.size()), 32'd0);
        check("final_ferr_count", 32'(n_ferr), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
